// File: rtl/div11_pkg.sv
// Shared definitions for the divide-by-11 family and its reconstruction
// (re-multiply) datapath.
//
// Contents:
//   DIVISOR, R_W      constant divisor and remainder width
//   MAX_DIGIT_W, T_W  widest supported digit and the matching 11*d+c width
//   state_t           IDLE / RUN / DONE control states
//   mul11_digit()     one 11*d+c digit product, also used by bench models
package div11_pkg;

  localparam int DIVISOR     = 11;
  localparam int R_W         = 4;
  localparam int MAX_DIGIT_W = 8;
  localparam int T_W         = MAX_DIGIT_W + R_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry_out, digit_out} for a digit of up to MAX_DIGIT_W bits.
  // The result is exact for any 4-bit carry, including the 11..15 values
  // that an illegal remainder can produce:
  // 11*(2^D - 1) + 15 < 2^(D+4) for every D.
  function automatic logic [T_W-1:0] mul11_digit(
    input logic [MAX_DIGIT_W-1:0] digit,
    input logic [R_W-1:0]         carry
  );
    return T_W'(digit) * T_W'(DIVISOR) + T_W'(carry);
  endfunction

endpackage

// File: rtl/mul11_recon_serial_if.sv
// Operand/result handshake bundle for mul11_recon_serial.
//
// Signals:
//   in_valid, in_ready, in_q[Q_W], in_r[4]       operand side
//   out_valid, out_ready, out_x[Q_W+4],
//   out_ovf, out_rerr                            result side
//
// Modports:
//   master  producer/consumer side (drives operands, accepts results)
//   slave   the reconstruction block
interface mul11_recon_serial_if #(
  parameter int Q_W = 32
);
  import div11_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [Q_W-1:0]     in_q;
  logic [R_W-1:0]     in_r;
  logic               out_valid;
  logic               out_ready;
  logic [Q_W+R_W-1:0] out_x;
  logic               out_ovf;
  logic               out_rerr;

  modport master (
    output in_valid, in_q, in_r, out_ready,
    input  in_ready, out_valid, out_x, out_ovf, out_rerr
  );

  modport slave (
    input  in_valid, in_q, in_r, out_ready,
    output in_ready, out_valid, out_x, out_ovf, out_rerr
  );

endinterface

// File: rtl/mul11_recon_serial_digit_step.sv
// mul11_digit_step: the combinational DIGIT_W-bit slice of 11*d + c.
//
// Ports:
//   digit      in   DIGIT_W  current quotient digit
//   carry_in   in   4        carry from the previous digit
//   digit_out  out  DIGIT_W  low DIGIT_W bits of 11*digit + carry_in
//   carry_out  out  4        11*digit + carry_in >> DIGIT_W
module mul11_digit_step
  import div11_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic [R_W-1:0]     carry_in,
  output logic [DIGIT_W-1:0] digit_out,
  output logic [R_W-1:0]     carry_out
);

  logic [T_W-1:0] t_full;

  assign t_full    = mul11_digit(MAX_DIGIT_W'(digit), carry_in);
  assign digit_out = DIGIT_W'(t_full);
  assign carry_out = R_W'(t_full >> DIGIT_W);

endmodule

// File: rtl/mul11_recon_serial.sv
// mul11_recon_serial: rebuilds x = 11*q + r from a quotient and remainder,
// DIGIT_W quotient bits per cycle, least significant digit first.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of mul11_recon_serial_if:
//           in_valid/in_ready/in_q/in_r          operand handshake
//           out_valid/out_ready/out_x/out_ovf/
//           out_rerr                             result handshake
//
// Legal DIGIT_W values are 1, 2, 4 and 8; Q_W must be a multiple of DIGIT_W.
// A result appears N_DIG = Q_W/DIGIT_W edges after the accept edge and is
// held in DONE until the consumer takes it.
module mul11_recon_serial
  import div11_pkg::*;
#(
  parameter int Q_W     = 32,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul11_recon_serial_if.slave bus
);

  localparam int N_DIG = Q_W / DIGIT_W;
  localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  state_t             state, state_nxt;
  logic [Q_W-1:0]     q_sh;
  logic [Q_W-1:0]     res;
  logic [Q_W-1:0]     res_nxt;
  logic [R_W-1:0]     carry;
  logic [R_W-1:0]     carry_nxt;
  logic [DIGIT_W-1:0] digit_out;
  logic [CNT_W-1:0]   dig_cnt;
  logic               rerr;
  logic               last_dig;

  logic [Q_W+R_W-1:0] out_x_q;
  logic               out_ovf_q;
  logic               out_rerr_q;

  mul11_digit_step #(
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .digit     (q_sh[DIGIT_W-1:0]),
    .carry_in  (carry),
    .digit_out (digit_out),
    .carry_out (carry_nxt)
  );

  // Product digits enter from the MSB side, so after N_DIG shifts the first
  // (least significant) digit has arrived at bit 0.
  assign res_nxt  = Q_W'({digit_out, res} >> DIGIT_W);
  assign last_dig = (dig_cnt == CNT_W'(N_DIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_dig)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake flags come straight from the state register, so there is no
  // combinational path from any input to any output.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sh       <= '0;
      res        <= '0;
      carry      <= '0;
      rerr       <= 1'b0;
      dig_cnt    <= '0;
      out_x_q    <= '0;
      out_ovf_q  <= 1'b0;
      out_rerr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_sh    <= bus.in_q;
            carry   <= bus.in_r;
            rerr    <= (bus.in_r >= R_W'(DIVISOR));
            dig_cnt <= '0;
          end
        end
        RUN: begin
          q_sh    <= q_sh >> DIGIT_W;
          res     <= res_nxt;
          carry   <= carry_nxt;
          dig_cnt <= dig_cnt + CNT_W'(1);
          if (last_dig) begin
            // The final carry is the top R_W bits of 11*q + r.
            out_x_q    <= {carry_nxt, res_nxt};
            out_ovf_q  <= (carry_nxt != '0);
            out_rerr_q <= rerr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_x    = out_x_q;
  assign bus.out_ovf  = out_ovf_q;
  assign bus.out_rerr = out_rerr_q;

endmodule
